// File: rtl/motoro_commutation_seq.sv
// Six-step commutation sequencer for a three-phase half-bridge.
// Turns run, stop, direction and speed controls into registered gate drives.
// An all-off dead time separates consecutive steps. The step period ramps
// toward a clamped target.
module motoro_commutation_seq #(
  parameter int unsigned DEAD_CYC     = 50,
  parameter int unsigned PERIOD_START = 600000,
  parameter int unsigned TARGET_INIT  = 50000,
  parameter int unsigned PERIOD_MIN   = 5000,
  parameter int unsigned PERIOD_MAX   = 1000000,
  parameter int unsigned PERIOD_DELTA = 10000,
  parameter int unsigned RAMP_DELTA   = 20000
) (
  input  logic       clk50mhz,
  input  logic       reset,
  input  logic       m3start,
  input  logic       m3forceStop,
  input  logic       m3invRotate,
  input  logic       m3freqINC,
  input  logic       m3freqDEC,
  output logic       aHP,
  output logic       bHP,
  output logic       cHP,
  output logic       aLN,
  output logic       bLN,
  output logic       cLN,
  output logic [2:0] stepIdx,
  output logic       stepPulse,
  output logic       running
);

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_t;

  localparam logic [19:0] DEAD_L    = 20'(DEAD_CYC);
  localparam logic [19:0] START_L   = 20'(PERIOD_START);
  localparam logic [19:0] TINIT_L   = 20'(TARGET_INIT);
  localparam logic [19:0] MIN_L     = 20'(PERIOD_MIN);
  localparam logic [19:0] MAX_L     = 20'(PERIOD_MAX);
  localparam logic [19:0] PDELTA_L  = 20'(PERIOD_DELTA);
  localparam logic [19:0] RDELTA_L  = 20'(RAMP_DELTA);
  // Thresholds for compare-before-add/subtract clamping of the target.
  localparam logic [19:0] DEC_FLOOR = 20'(PERIOD_MIN + PERIOD_DELTA);
  localparam logic [19:0] INC_CEIL  = 20'(PERIOD_MAX - PERIOD_DELTA);

  // Gate vector order: {aHP, bHP, cHP, aLN, bLN, cLN}.
  localparam logic [5:0] GATES_OFF = 6'b111_000;

  state_t      state;
  logic [19:0] cnt;
  logic [19:0] period_reg;
  logic [19:0] target_reg;
  logic        fault_latch;
  logic        inc_q;
  logic        dec_q;
  logic [5:0]  gate_q;

  logic        inc_edge;
  logic        dec_edge;
  logic [19:0] target_next;
  logic [19:0] period_ramped;
  logic [2:0]  step_next;

  // Step pattern: high-side phase on (active-low), low-side phase on (active-high).
  function automatic logic [5:0] gate_pattern(input logic [2:0] s);
    case (s)
      3'd0:    return 6'b011_010;  // A high, B low
      3'd1:    return 6'b011_001;  // A high, C low
      3'd2:    return 6'b101_001;  // B high, C low
      3'd3:    return 6'b101_100;  // B high, A low
      3'd4:    return 6'b110_100;  // C high, A low
      3'd5:    return 6'b110_010;  // C high, B low
      default: return GATES_OFF;
    endcase
  endfunction

  assign {aHP, bHP, cHP, aLN, bLN, cLN} = gate_q;

  // Next-value arithmetic: target clamp, period ramp, step advance.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    inc_edge      = m3freqINC & ~inc_q;
    dec_edge      = m3freqDEC & ~dec_q;
    target_next   = target_reg;
    period_ramped = period_reg;
    step_next     = stepIdx;

    if (inc_edge && !dec_edge) begin
      target_next = (target_reg >= DEC_FLOOR) ? target_reg - PDELTA_L : MIN_L;
    end else if (dec_edge && !inc_edge) begin
      target_next = (target_reg <= INC_CEIL) ? target_reg + PDELTA_L : MAX_L;
    end

    if (period_reg > target_reg) begin
      period_ramped = (period_reg - target_reg > RDELTA_L) ? period_reg - RDELTA_L : target_reg;
    end else if (period_reg < target_reg) begin
      period_ramped = (target_reg - period_reg > RDELTA_L) ? period_reg + RDELTA_L : target_reg;
    end

    // Direction is taken from m3invRotate at the boundary itself, so a
    // mid-step change only takes effect on the next advance.
    if (m3invRotate) begin
      step_next = (stepIdx == 3'd0) ? 3'd5 : stepIdx - 3'd1;
    end else begin
      step_next = (stepIdx == 3'd5) ? 3'd0 : stepIdx + 3'd1;
    end
  end

  // Sequencer FSM with registered gate, step and status outputs.
  always_ff @(posedge clk50mhz or posedge reset) begin
    // NOTE: the gate register is in the async reset branch so the bridge goes safe without a clock.
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      period_reg  <= START_L;
      target_reg  <= TINIT_L;
      fault_latch <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      gate_q      <= GATES_OFF;
      stepIdx     <= 3'd0;
      stepPulse   <= 1'b0;
      running     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      inc_q      <= m3freqINC;
      dec_q      <= m3freqDEC;
      target_reg <= target_next;
      stepPulse  <= 1'b0;

      if (m3forceStop) begin
        state       <= IDLE;
        fault_latch <= 1'b1;
        gate_q      <= GATES_OFF;
        running     <= 1'b0;
      end else if (!m3start) begin
        state       <= IDLE;
        fault_latch <= 1'b0;
        gate_q      <= GATES_OFF;
        running     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!fault_latch) begin
              state      <= DEAD;
              cnt        <= DEAD_L;
              stepIdx    <= 3'd0;
              period_reg <= START_L;
              running    <= 1'b1;
            end
          end
          DEAD: begin
            if (cnt == 20'd1) begin
              state     <= DRIVE;
              cnt       <= period_reg;
              stepPulse <= 1'b1;
              gate_q    <= gate_pattern(stepIdx);
            end else begin
              cnt <= cnt - 20'd1;
            end
          end
          DRIVE: begin
            if (cnt == 20'd1) begin
              state      <= DEAD;
              cnt        <= DEAD_L;
              stepIdx    <= step_next;
              period_reg <= period_ramped;
              gate_q     <= GATES_OFF;
            end else begin
              cnt <= cnt - 20'd1;
            end
          end
          default: begin
            state  <= IDLE;
            gate_q <= GATES_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motoro_commutation_seq.sv
// Bench for motoro_commutation_seq: directed scenarios with literal step
// lengths and patterns, followed by random stimulus. A cycle model
// built from the step/dead-time rules is compared on every falling edge.
module tb_motoro_commutation_seq;

  localparam int DEAD   = 4;
  localparam int PSTART = 40;
  localparam int TINIT  = 16;
  localparam int PMIN   = 8;
  localparam int PMAX   = 64;
  localparam int PDELTA = 8;
  localparam int RDELTA = 8;
  localparam int BOUND  = 2000;

  logic       clk50mhz = 1'b0;
  logic       reset = 1'b1;
  logic       m3start = 1'b0;
  logic       m3forceStop = 1'b0;
  logic       m3invRotate = 1'b0;
  logic       m3freqINC = 1'b0;
  logic       m3freqDEC = 1'b0;
  logic       aHP, bHP, cHP, aLN, bLN, cLN;
  logic [2:0] stepIdx;
  logic       stepPulse;
  logic       running;

  int total = 0;
  int bad = 0;

  motoro_commutation_seq #(
    .DEAD_CYC(DEAD), .PERIOD_START(PSTART), .TARGET_INIT(TINIT),
    .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX), .PERIOD_DELTA(PDELTA), .RAMP_DELTA(RDELTA)
  ) dut (
    .clk50mhz(clk50mhz), .reset(reset), .m3start(m3start), .m3forceStop(m3forceStop),
    .m3invRotate(m3invRotate), .m3freqINC(m3freqINC), .m3freqDEC(m3freqDEC),
    .aHP(aHP), .bHP(bHP), .cHP(cHP), .aLN(aLN), .bLN(bLN), .cLN(cLN),
    .stepIdx(stepIdx), .stepPulse(stepPulse), .running(running)
  );

  always #5 clk50mhz = ~clk50mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase index (0=A, 1=B, 2=C) switched on by each step.
  int hp_tab[6] = '{0, 0, 1, 1, 2, 2};
  int ln_tab[6] = '{1, 2, 2, 0, 0, 1};
  // Hand-written gate vectors {aHP,bHP,cHP,aLN,bLN,cLN} for each step.
  logic [5:0] gates_lit[6] = '{6'b011010, 6'b011001, 6'b101001, 6'b101100, 6'b110100, 6'b110010};

  // Behavioural model: run flag, drive/dead phase, cycles left, step, periods.
  bit m_run, m_drive, m_fault, m_pinc, m_pdec, m_pulse;
  int m_left, m_step, m_period, m_target, m_d;
  bit inc_e, dec_e;

  always @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      m_run = 0; m_drive = 0; m_fault = 0; m_pinc = 0; m_pdec = 0; m_pulse = 0;
      m_left = 0; m_step = 0; m_period = PSTART; m_target = TINIT;
    end else begin
      inc_e = m3freqINC && !m_pinc;
      dec_e = m3freqDEC && !m_pdec;
      m_pulse = 0;
      if (m3forceStop) begin
        m_fault = 1; m_run = 0; m_drive = 0;
      end else if (!m3start) begin
        m_fault = 0; m_run = 0; m_drive = 0;
      end else if (!m_run) begin
        if (!m_fault) begin
          m_run = 1; m_drive = 0; m_left = DEAD; m_step = 0; m_period = PSTART;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (!m_drive) begin
            m_drive = 1; m_left = m_period; m_pulse = 1;
          end else begin
            m_drive = 0; m_left = DEAD;
            m_step = m3invRotate ? (m_step + 5) % 6 : (m_step + 1) % 6;
            m_d = m_target - m_period;
            if (m_d > RDELTA) m_d = RDELTA;
            if (m_d < -RDELTA) m_d = -RDELTA;
            m_period = m_period + m_d;
          end
        end
      end
      if (inc_e && !dec_e) m_target = (m_target - PDELTA < PMIN) ? PMIN : m_target - PDELTA;
      if (dec_e && !inc_e) m_target = (m_target + PDELTA > PMAX) ? PMAX : m_target + PDELTA;
      m_pinc = m3freqINC;
      m_pdec = m3freqDEC;
    end
  end

  // Per-cycle compare against the model plus the bridge safety monitor.
  logic [2:0] e_hp, e_ln;
  always @(negedge clk50mhz) begin
    e_hp = 3'b111;
    e_ln = 3'b000;
    if (m_run && m_drive) begin
      e_hp[2 - hp_tab[m_step]] = 1'b0;
      e_ln[2 - ln_tab[m_step]] = 1'b1;
    end
    check("outputs", {20'd0, aHP, bHP, cHP, aLN, bLN, cLN, stepIdx, stepPulse, running},
          {20'd0, e_hp, e_ln, 3'(m_step), m_pulse, m_run});
    check("safety", {31'd0, ((~{aHP, bHP, cHP} & {aLN, bLN, cLN}) != 3'b000) ||
                            ($countones(~{aHP, bHP, cHP}) > 1)}, 32'd0);
  end

  // From a negedge in the dead phase (or idle just after start), count running
  // off cycles up to stepPulse, then count the cycles the pattern is held.
  task automatic measure_step(input int exp_step, input int exp_len, input bit flip);
    int d = 0;
    int n = 0;
    while (!stepPulse && d < BOUND) begin
      if (running) d++;
      @(negedge clk50mhz);
    end
    check($sformatf("dead_before_step%0d", exp_step), d, DEAD);
    check($sformatf("step_idx%0d", exp_step), {29'd0, stepIdx}, exp_step);
    check($sformatf("gates_step%0d", exp_step), {26'd0, aHP, bHP, cHP, aLN, bLN, cLN},
          {26'd0, gates_lit[exp_step]});
    if (flip) m3invRotate = ~m3invRotate;
    do begin
      n++;
      @(negedge clk50mhz);
    end while ({aHP, bHP, cHP, aLN, bLN, cLN} != 6'b111000 && n < BOUND);
    check($sformatf("len_step%0d", exp_step), n, exp_len);
  endtask

  task automatic restart();
    m3start = 1'b0;
    @(posedge clk50mhz); #1;
    m3start = 1'b1;
    @(negedge clk50mhz);
  endtask

  task automatic pulse_edge(input bit inc, input bit dec);
    @(posedge clk50mhz); #1;
    m3freqINC = inc; m3freqDEC = dec;
    @(posedge clk50mhz); #1;
    m3freqINC = 1'b0; m3freqDEC = 1'b0;
  endtask

  task automatic wait_pulse();
    int w = 0;
    while (!stepPulse && w < BOUND) begin
      w++;
      @(negedge clk50mhz);
    end
    check("wait_pulse", {31'd0, stepPulse}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk50mhz);
    #1;
    check("reset_state", {20'd0, aHP, bHP, cHP, aLN, bLN, cLN, stepIdx, stepPulse, running},
          {20'd0, 12'b111_000_000_0_0});
    reset = 1'b0;

    // Forward start with ramp 40, 32, 24, 16 and wrap 5 -> 0.
    restart();
    measure_step(0, 40, 0); measure_step(1, 32, 0); measure_step(2, 24, 0);
    measure_step(3, 16, 0); measure_step(4, 16, 0); measure_step(5, 16, 0);
    measure_step(0, 16, 0);
    m3start = 1'b0;
    @(posedge clk50mhz); #1;
    check("stop_running", {31'd0, running}, 32'd0);

    // Reverse, with a mid-DRIVE toggle taking effect at the next boundary.
    m3invRotate = 1'b1;
    restart();
    measure_step(0, 40, 0); measure_step(5, 32, 0); measure_step(4, 24, 1);
    measure_step(5, 16, 0); measure_step(0, 16, 0);

    // Force stop during step 2, no restart while start stays high.
    m3invRotate = 1'b0;
    restart();
    measure_step(0, 40, 0); measure_step(1, 32, 0);
    wait_pulse();
    check("fs_step", {29'd0, stepIdx}, 32'd2);
    m3forceStop = 1'b1;
    @(posedge clk50mhz); #1;
    m3forceStop = 1'b0;
    check("fs_gates", {26'd0, aHP, bHP, cHP, aLN, bLN, cLN}, {26'd0, 6'b111000});
    check("fs_running", {31'd0, running}, 32'd0);
    repeat (20) @(negedge clk50mhz);
    check("fs_no_restart", {31'd0, running}, 32'd0);
    restart();
    measure_step(0, 40, 0);

    // Speed: three INC edges clamp the target at 8; INC+DEC together is ignored.
    m3start = 1'b0;
    repeat (3) pulse_edge(1, 0);
    pulse_edge(1, 1);
    restart();
    measure_step(0, 40, 0); measure_step(1, 32, 0); measure_step(2, 24, 0);
    measure_step(3, 16, 0); measure_step(4, 8, 0); measure_step(5, 8, 0);
    m3start = 1'b0;
    repeat (10) pulse_edge(0, 1);
    restart();
    measure_step(0, 40, 0); measure_step(1, 48, 0); measure_step(2, 56, 0);
    measure_step(3, 64, 0); measure_step(4, 64, 0);

    // Reset mid-DRIVE: gates safe without a clock edge, target back to 16.
    m3start = 1'b0;
    repeat (3) pulse_edge(1, 0);
    restart();
    measure_step(0, 40, 0);
    wait_pulse();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_gates", {26'd0, aHP, bHP, cHP, aLN, bLN, cLN}, {26'd0, 6'b111000});
    check("async_reset_running", {31'd0, running}, 32'd0);
    @(posedge clk50mhz); #3;
    reset = 1'b0;
    @(negedge clk50mhz);
    measure_step(0, 40, 0); measure_step(1, 32, 0); measure_step(2, 24, 0);
    measure_step(3, 16, 0);

    // Random stimulus checked by the model on every cycle.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk50mhz); #1;
      reset = 1'b0;
      m3forceStop = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 199) == 0) m3start = ~m3start;
      if ($urandom_range(0, 49) == 0) m3invRotate = ~m3invRotate;
      m3freqINC = ($urandom_range(0, 29) == 0) ? ~m3freqINC : m3freqINC;
      m3freqDEC = ($urandom_range(0, 29) == 0) ? ~m3freqDEC : m3freqDEC;
      if (!m3start && $urandom_range(0, 9) == 0) m3start = 1'b1;
      if ($urandom_range(0, 1999) == 0) begin
        #2;
        reset = 1'b1;
      end
    end
    @(negedge clk50mhz);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
